// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl
// Sequences the per-row input buffers on the west edge of the systolic array.
// A job loads a length-len vector into every row buffer, then reads the
// buffers back with a one-cycle-per-row diagonal skew. It waits for the array
// to drain and then pulses done. Only control and valid/flush signals are
// driven here; buffer data paths bypass this block.
//
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_start, i_len  job request (sampled only in IDLE), vector length 1..CAP
//   i_abort         abandon the current job (ignored in IDLE)
//   i_load_valid    load beat present on the buffer write-data buses
//   o_load_ready    controller is accepting load beats
//   o_buf_wr        per-buffer write strobe
//   o_buf_rd        per-buffer read/advance strobe
//   o_feed_valid    per-row valid toward the array
//   o_buf_rst_n     active-low one-cycle flush of the row buffers after abort
//   o_busy, o_done  job in progress, one-cycle completion pulse
//   o_err           one-cycle pulse on an illegal i_len at start
module systolic_feed_ctrl #(
    parameter int unsigned ROWS         = 3,
    parameter int unsigned ADDR_WIDTH   = 2,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic                  i_abort,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    output logic [ROWS-1:0]       o_buf_wr,
    output logic [ROWS-1:0]       o_buf_rd,
    output logic [ROWS-1:0]       o_feed_valid,
    output logic                  o_buf_rst_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int unsigned CAP = 2 ** ADDR_WIDTH;
    localparam int unsigned LW  = ADDR_WIDTH + 1;
    // Skew counter must reach CAP+ROWS-2 (last feed beat index).
    localparam int unsigned TW  = $clog2(CAP + ROWS);
    localparam int unsigned DW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFeed,
        StDrain,
        StDone,
        StFlush
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   t_q, t_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            err_q, err_d;

    logic len_ok;
    logic feed_last;
    logic drain_last;

    assign len_ok     = (i_len != '0) && (32'(i_len) <= CAP);
    // FEED spans len+ROWS-1 beats, so the last one has t = len+ROWS-2.
    assign feed_last  = (32'(t_q) + 32'd2) == (32'(len_q) + ROWS);
    assign drain_last = (32'(drain_q) + 32'd1) >= DRAIN_CYCLES;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            t_q     <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        drain_d = drain_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (len_ok) begin
                        len_d   = i_len;
                        cnt_d   = '0;
                        t_d     = '0;
                        drain_d = '0;
                        state_d = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (i_load_valid) begin
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_q + LW'(1) == len_q) begin
                        t_d     = '0;
                        state_d = StFeed;
                    end
                end
            end
            StFeed: begin
                t_d = t_q + TW'(1);
                if (feed_last) begin
                    drain_d = '0;
                    state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                drain_d = drain_q + DW'(1);
                if (drain_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort overrides every other transition once a job is under way.
        if (i_abort && (state_q inside {StLoad, StFeed, StDrain, StDone})) begin
            state_d = StFlush;
        end
    end

    // Diagonal skew: row r is valid for t in [r, r+len).
    always_comb begin
        o_feed_valid = '0;
        if (state_q == StFeed) begin
            for (int r = 0; r < ROWS; r++) begin
                o_feed_valid[r] = (32'(t_q) >= 32'(r)) && (32'(t_q) < 32'(r) + 32'(len_q));
            end
        end
    end

    // wr only in LOAD and rd only in FEED, so they can never coincide.
    assign o_buf_wr     = (state_q == StLoad) ? {ROWS{i_load_valid}} : '0;
    assign o_buf_rd     = o_feed_valid;

    assign o_load_ready = (state_q == StLoad);
    assign o_busy       = (state_q != StIdle);
    assign o_done       = (state_q == StDone);
    assign o_buf_rst_n  = (state_q != StFlush);
    assign o_err        = err_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl. Each job is described by its
// length and optional abort/reset point; expected strobes are derived per cycle
// from the job timeline (load beats, skewed feed window, drain, done).
module tb_systolic_feed_ctrl;

    localparam int ROWS  = 3;
    localparam int AW    = 2;
    localparam int DRAIN = 2;
    localparam int CAP   = 4;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_start;
    logic [AW:0]     i_len;
    logic            i_abort;
    logic            i_load_valid;
    logic            o_load_ready;
    logic [ROWS-1:0] o_buf_wr;
    logic [ROWS-1:0] o_buf_rd;
    logic [ROWS-1:0] o_feed_valid;
    logic            o_buf_rst_n;
    logic            o_busy;
    logic            o_done;
    logic            o_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    systolic_feed_ctrl #(
        .ROWS         (ROWS),
        .ADDR_WIDTH   (AW),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_abort      (i_abort),
        .i_load_valid (i_load_valid),
        .o_load_ready (o_load_ready),
        .o_buf_wr     (o_buf_wr),
        .o_buf_rd     (o_buf_rd),
        .o_feed_valid (o_feed_valid),
        .o_buf_rst_n  (o_buf_rst_n),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_cycle(input string ph, input logic ready, input logic [ROWS-1:0] wr,
                                input logic [ROWS-1:0] fv, input logic busy, input logic done,
                                input logic err, input logic brst);
        check_eq({ph, ".ready"}, 32'(o_load_ready), 32'(ready));
        check_eq({ph, ".wr"},    32'(o_buf_wr),     32'(wr));
        check_eq({ph, ".fv"},    32'(o_feed_valid), 32'(fv));
        check_eq({ph, ".rd"},    32'(o_buf_rd),     32'(fv));
        check_eq({ph, ".busy"},  32'(o_busy),       32'(busy));
        check_eq({ph, ".done"},  32'(o_done),       32'(done));
        check_eq({ph, ".err"},   32'(o_err),        32'(err));
        check_eq({ph, ".brst"},  32'(o_buf_rst_n),  32'(brst));
        check_eq({ph, ".excl"},  32'(o_buf_wr & o_buf_rd), 32'd0);
    endtask

    // Expected skewed feed pattern for beat k of a length-len job.
    function automatic logic [ROWS-1:0] feed_pat(input int k, input int len);
        logic [ROWS-1:0] p;
        p = '0;
        for (int r = 0; r < ROWS; r++) p[r] = (k >= r) && (k < r + len);
        return p;
    endfunction

    // abort_k >= 0: abort on feed beat abort_k. rst_beats >= 0: reset after that many beats.
    task automatic do_job(input int len, input int abort_k, input int rst_beats);
        int beats;
        int ncyc;
        int rd_cnt[ROWS];
        int wr_cnt[ROWS];
        logic [ROWS-1:0] fv;
        for (int r = 0; r < ROWS; r++) begin
            rd_cnt[r] = 0;
            wr_cnt[r] = 0;
        end

        // IDLE: start (abort in IDLE must be ignored, load beats too)
        @(negedge i_clk);
        i_start = 1'b1; i_len = (AW+1)'(len);
        i_load_valid = 1'($urandom); i_abort = 1'($urandom);
        #1 expect_cycle("idle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        beats = 0;
        ncyc  = 0;
        while (beats < len) begin
            @(negedge i_clk);
            i_start = 1'($urandom); i_len = (AW+1)'($urandom); i_abort = 1'b0;
            if (rst_beats >= 0 && beats == rst_beats) begin
                i_load_valid = 1'b0; i_rst_n = 1'b0;
                #1 expect_cycle("ld_rst", 1'b1, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
                @(negedge i_clk);
                i_rst_n = 1'b1; i_start = 1'b0;
                #1 expect_cycle("post_rst", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            i_load_valid = ($urandom % 3) != 0;
            if (ncyc == 1) i_load_valid = 1'b0;  // guarantee at least one gap when len > 1
            #1 expect_cycle("load", 1'b1, {ROWS{i_load_valid}}, '0, 1'b1, 1'b0, 1'b0, 1'b1);
            for (int r = 0; r < ROWS; r++) wr_cnt[r] += int'(o_buf_wr[r]);
            if (i_load_valid) beats++;
            ncyc++;
        end

        for (int k = 0; k < len + ROWS - 1; k++) begin
            @(negedge i_clk);
            i_start = 1'($urandom); i_load_valid = 1'($urandom);
            i_abort = (k == abort_k);
            fv = feed_pat(k, len);
            #1 expect_cycle("feed", 1'b0, '0, fv, 1'b1, 1'b0, 1'b0, 1'b1);
            for (int r = 0; r < ROWS; r++) rd_cnt[r] += int'(o_buf_rd[r]);
            if (k == abort_k) begin
                @(negedge i_clk);
                i_abort = 1'($urandom); i_load_valid = 1'($urandom); i_start = 1'($urandom);
                #1 expect_cycle("flush", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
                @(negedge i_clk);
                i_abort = 1'b0; i_start = 1'b0;
                #1 expect_cycle("post_flush", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
        end

        for (int d = 0; d < DRAIN; d++) begin
            @(negedge i_clk);
            i_start = 1'($urandom); i_load_valid = 1'($urandom); i_abort = 1'b0;
            #1 expect_cycle("drain", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        end

        @(negedge i_clk);
        i_start = 1'($urandom); i_load_valid = 1'($urandom); i_abort = 1'b0;
        #1 expect_cycle("done", 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1);

        for (int r = 0; r < ROWS; r++) begin
            check_eq("rd_count", 32'(rd_cnt[r]), 32'(len));
            check_eq("wr_count", 32'(wr_cnt[r]), 32'(len));
        end
    endtask

    task automatic do_illegal(input int len);
        @(negedge i_clk);
        i_start = 1'b1; i_len = (AW+1)'(len);
        i_load_valid = 1'($urandom); i_abort = 1'($urandom);
        #1 expect_cycle("ill_start", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge i_clk);
        i_start = 1'b0; i_abort = 1'b0; i_load_valid = 1'($urandom);
        #1 expect_cycle("ill_err", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge i_clk);
        i_load_valid = 1'($urandom);
        #1 expect_cycle("ill_after", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int sel;
        int len;
        i_rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_abort = 1'b0; i_load_valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_start = 1'($urandom); i_len = (AW+1)'($urandom);
            i_abort = 1'($urandom); i_load_valid = 1'($urandom);
            #1 expect_cycle("reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        #1 expect_cycle("rst_rel", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        do_job(4, -1, -1);
        do_job(1, -1, -1);
        do_illegal(0);
        do_illegal(5);
        do_job(4, -1, -1);
        do_job(4, 2, -1);
        do_job(4, -1, -1);
        do_job(4, -1, 2);
        do_job(4, -1, -1);
        do_job(2, -1, -1);
        do_job(3, -1, -1);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom % 6;
            len = 1 + ($urandom % CAP);
            case (sel)
                0: do_illegal(($urandom % 2) ? 0 : CAP + 1 + ($urandom % 3));
                1: do_job(len, $urandom % (len + ROWS - 1), -1);
                2: do_job(len, -1, $urandom % len);
                default: do_job(len, -1, -1);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencing controller for the bank of per-row input buffers that feed the systolic array's west edge. It issues write strobes while a length-`len` operand vector is loaded into every row buffer. It then issues read strobes with a one-cycle-per-row diagonal skew, so that row `r` starts streaming `r` cycles after row 0. After the array pipeline drains it pulses done. Buffer data paths bypass this block; it drives only the control and valid/flush signals.

## Interface
- `ROWS`, 3: number of row buffers/array rows.
- `ADDR_WIDTH`, 2: row-buffer address width; capacity `CAP = 2**ADDR_WIDTH`.
- `DRAIN_CYCLES`, 2: cycles to wait after the last feed beat for the array to flush (0 allowed).
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_start`  in  1  start a job; sampled only in IDLE.
- `i_len`  in  ADDR_WIDTH+1  vector length, sampled with `i_start`; legal range 1..CAP.
- `i_abort`  in  1  abandon the current job, from any non-IDLE state.
- `i_load_valid`  in  1  load-side beat present on the buffer write-data buses.
- `o_load_ready`  out  1  controller accepts load beats (LOAD state).
- `o_buf_wr`  out  ROWS  per-buffer write strobe.
- `o_buf_rd`  out  ROWS  per-buffer read/advance strobe.
- `o_feed_valid`  out  ROWS  per-row valid toward the array; the array substitutes zero when low.
- `o_buf_rst_n`  out  1  active-low flush for the row buffers; the integrator ANDs it with `i_rst_n`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle job-complete pulse.
- `o_err`  out  1  one-cycle pulse on an illegal `i_len` at start.

## Operation
- States: IDLE, LOAD, FEED, DRAIN, DONE, FLUSH.
- Registers: `len_q` (ADDR_WIDTH+1), beat counter `cnt` (ADDR_WIDTH+1), skew counter `t` (wide enough for `CAP+ROWS-1`), drain counter.
- IDLE:
  - On `i_start` with 1 ≤ `i_len` ≤ CAP: latch `len_q`, clear counters, go to LOAD.
  - On `i_start` with `i_len` = 0 or > CAP: pulse `o_err` next cycle and stay in IDLE.
  - Load beats in IDLE are ignored.
- LOAD:
  - `o_load_ready` = 1.
  - `o_buf_wr = {ROWS{i_load_valid}}` (combinational).
  - Each accepted beat increments `cnt`.
  - When the `len_q`-th beat is accepted, go to FEED with `t` = 0. Gaps in `i_load_valid` are allowed.
- FEED:
  - `o_feed_valid[r] = (t >= r) && (t < r + len_q)`.
  - `o_buf_rd = o_feed_valid`. Buffer data is combinational at the read pointer, so the rd strobe consumes the word being presented.
  - `t` increments each cycle. FEED lasts exactly `len_q + ROWS - 1` cycles, then goes to DRAIN, or to DONE if `DRAIN_CYCLES` = 0.
- DRAIN: count `DRAIN_CYCLES` cycles with all strobes low, then go to DONE.
- DONE: `o_done` = 1 for one cycle, then go to IDLE.
- `i_abort` in LOAD/FEED/DRAIN/DONE: go to FLUSH next cycle. FLUSH drives `o_buf_rst_n` = 0 for exactly one cycle, clearing buffer pointers that are now misaligned, then goes to IDLE. Abort has priority over every other transition.
- Invariant: `o_buf_wr[r]` and `o_buf_rd[r]` are never high in the same cycle, because the buffers ignore simultaneous rd+wr.
- Across a job, each buffer receives exactly `len_q` writes and `len_q` reads, so its pointers return to equal values.

## Timing
- Reset:
  - state IDLE, all counters 0.
  - `o_load_ready`, `o_buf_wr`, `o_buf_rd`, `o_feed_valid`, `o_busy`, `o_done`, `o_err` = 0.
  - `o_buf_rst_n` = 1.
- Reset mid-job returns to IDLE on the next edge. The buffers are cleared by `i_rst_n` itself.
- Start to first `o_load_ready`: 1 cycle.
- Last accepted load beat to first `o_feed_valid`: 1 cycle.
- Last feed beat to `o_done`: `DRAIN_CYCLES` + 1 cycles.
- `o_busy` is high from the cycle after start through the DONE cycle, and during FLUSH.
- `o_busy` is low in the cycle after DONE. A new `i_start` is accepted in that cycle.
- `i_start` while busy is ignored.
- `i_abort` in IDLE is ignored.
- `o_buf_wr`, `o_buf_rd`, and `o_feed_valid` are combinational from registered state plus `i_load_valid`. All other outputs are registered.

## Test plan
- **Reset:** hold `i_rst_n`=0 for 3 cycles with random inputs → all outputs at their reset values, `o_busy`=0.
- **Nominal job** (ROWS=3, len=4, DRAIN_CYCLES=2): start, then 4 load beats with one idle gap.
  - `o_buf_wr`=3'b111 on exactly the 4 accepted beats.
  - FEED `o_feed_valid`/`o_buf_rd` sequence: 001, 011, 111, 111, 110, 100.
  - 2 idle cycles, then `o_done` for 1 cycle.
  - Each buffer is read exactly 4 times.
- **len=1:** feed sequence 001, 010, 100, then `o_done` after 2 drain cycles.
- **Illegal length:** `i_len`=0, and separately `i_len`=5 → `o_err` pulses once, `o_busy` stays 0, no strobes. A following legal start completes normally.
- **Abort:** assert `i_abort` in FEED at `t`=2 → next cycle FLUSH with `o_buf_rst_n`=0 for 1 cycle, then IDLE. All strobes are low during FLUSH. A subsequent len=4 job produces the nominal sequence.
- **Reset during LOAD:** drop `i_rst_n` after 2 beats → IDLE next edge, no `o_done`. The next job loads and feeds 4 beats correctly.
